muldiv_seq: RTL and testbench

- Multi-cycle multiply/divide sequencer that sits beside the EX-stage ALU.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and runs a 32-iteration shift-add or restoring-divide loop.
- Owns the architectural HI/LO registers.
- Drives a stall request to the pipeline control whenever EX needs HI/LO, or the unit itself, while an operation is in flight.

---
 rtl/muldiv_pkg.sv | 42 ++++
 rtl/muldiv_step.sv | 37 +++
 rtl/muldiv_seq.sv | 187 ++++++++++++++++++
 tb/tb_muldiv_seq.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the multiply/divide sequencer.
//   - md_op_e    : 3-bit op codes presented by EX
//   - md_state_e : sequencer FSM states
//   - ITER/CNT_W : iteration count and matching counter width
//   - STEP_MUL/STEP_DIV : iteration mode select for muldiv_step
package muldiv_pkg;

  localparam int ITER  = 32;
  localparam int CNT_W = $clog2(ITER);

  localparam logic STEP_MUL = 1'b0;
  localparam logic STEP_DIV = 1'b1;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } md_state_e;

  // MULT/MULTU/DIV/DIVU occupy codes 0..3; everything above is a move or unused.
  function automatic logic is_arith(input logic [2:0] op);
    return (op <= 3'd3);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the multiply/divide loop.
//   mode     in  1   STEP_MUL (shift-add) or STEP_DIV (restoring divide)
//   acc      in  64  working accumulator
//                    mul: {partial product upper, multiplier / product lower}
//                    div: {partial remainder, dividend / quotient bits}
//   operand  in  32  multiplicand (mul) or divisor (div), unsigned magnitude
//   acc_next out 64  accumulator after this iteration
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic        mode,
  input  logic [63:0] acc,
  input  logic [31:0] operand,
  output logic [63:0] acc_next
);

  logic [32:0] sum;
  logic [32:0] shifted;
  logic [32:0] trial;

  always_comb begin
    // Multiply: conditional add into the upper half, carry kept as bit 32.
    sum     = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
    // Divide: bring the next dividend bit into the remainder and try a subtract.
    shifted = {acc[63:32], acc[31]};
    trial   = shifted - {1'b0, operand};

    if (mode == STEP_DIV) begin
      // The remainder stays below the divisor, so 32 bits hold it after either branch.
      if (!trial[32]) acc_next = {trial[31:0], acc[30:0], 1'b1};
      else            acc_next = {shifted[31:0], acc[30:0], 1'b0};
    end else begin
      acc_next = {sum, acc[31:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle MIPS-I multiply/divide sequencer with HI/LO.
//   i_clk      in  1   clock, rising edge
//   i_rst      in  1   asynchronous active-high reset
//   i_start    in  1   EX presents a muldiv op this cycle
//   i_op       in  3   md_op_e op code
//   i_src1     in  32  rs (multiplicand / dividend / MTHI-MTLO data)
//   i_src2     in  32  rt (multiplier / divisor)
//   i_hilo_rd  in  1   EX holds MFHI/MFLO this cycle
//   o_busy     out 1   RUN or FIX
//   o_stall    out 1   freeze IF/ID/EX (combinational)
//   o_done     out 1   one-cycle pulse after a MULT/DIV HI/LO write
//   o_hi       out 32  HI register
//   o_lo       out 32  LO register
//
// state  | meaning
// S_IDLE | waiting; MTHI/MTLO write here, arithmetic ops are latched
// S_RUN  | ITER iterations of muldiv_step, count ITER-1 down to 0
// S_FIX  | sign correction, special cases, HI/LO write
module muldiv_seq
  import muldiv_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_src1,
  input  logic [31:0] i_src2,
  input  logic        i_hilo_rd,
  output logic        o_busy,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  md_state_e        state, state_next;
  logic [CNT_W-1:0] count;
  logic [63:0]      acc;
  logic [63:0]      acc_next;
  logic [31:0]      operand;
  logic [31:0]      src1_raw;
  logic             div_mode;
  logic             neg_a;
  logic             neg_b;
  logic             div_zero;
  logic             div_ovf;
  logic [31:0]      hi, lo;
  logic             done;

  logic             accept;
  logic             sgn_a, sgn_b;
  logic [31:0]      mag_a, mag_b;
  logic [63:0]      prod_fix;
  logic [31:0]      quo_fix, rem_fix;
  logic [31:0]      fix_hi, fix_lo;

  muldiv_step u_step (
    .mode     (div_mode),
    .acc      (acc),
    .operand  (operand),
    .acc_next (acc_next)
  );

  assign accept = (state == S_IDLE) && i_start && is_arith(i_op);

  // Signed ops work on magnitudes; 32'h8000_0000 negates to itself, which is
  // exactly 2^31 when read as unsigned.
  always_comb begin
    sgn_a = is_signed_op(i_op) & i_src1[31];
    sgn_b = is_signed_op(i_op) & i_src2[31];
    mag_a = sgn_a ? (32'd0 - i_src1) : i_src1;
    mag_b = sgn_b ? (32'd0 - i_src2) : i_src2;
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = S_RUN;
      S_RUN:   if (count == '0) state_next = S_FIX;
      S_FIX:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    o_busy = (state == S_RUN) || (state == S_FIX);
  end

  assign o_stall = o_busy & (i_start | i_hilo_rd);

  // Operand latch, counter and iteration datapath
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count    <= '0;
      acc      <= '0;
      operand  <= '0;
      src1_raw <= '0;
      div_mode <= STEP_MUL;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      div_zero <= 1'b0;
      div_ovf  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            count    <= CNT_W'(ITER - 1);
            src1_raw <= i_src1;
            neg_a    <= sgn_a;
            neg_b    <= sgn_b;
            div_zero <= is_div_op(i_op) && (i_src2 == 32'd0);
            div_ovf  <= (i_op == MD_DIV) && (i_src1 == 32'h8000_0000) &&
                        (i_src2 == 32'hFFFF_FFFF);
            if (is_div_op(i_op)) begin
              // Dividend sits in the low half and shifts into the remainder.
              div_mode <= STEP_DIV;
              acc      <= {32'd0, mag_a};
              operand  <= mag_b;
            end else begin
              // Multiplier in the low half; multiplicand is added to the upper.
              div_mode <= STEP_MUL;
              acc      <= {32'd0, mag_b};
              operand  <= mag_a;
            end
          end
        end
        S_RUN: begin
          acc <= acc_next;
          if (count != '0) count <= count - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Sign correction and special results for the FIX write
  always_comb begin
    prod_fix = (neg_a ^ neg_b) ? (64'd0 - acc) : acc;
    quo_fix  = (neg_a ^ neg_b) ? (32'd0 - acc[31:0]) : acc[31:0];
    rem_fix  = neg_a ? (32'd0 - acc[63:32]) : acc[63:32];
    fix_hi   = prod_fix[63:32];
    fix_lo   = prod_fix[31:0];
    if (div_mode == STEP_DIV) begin
      if (div_zero) begin
        fix_hi = src1_raw;
        fix_lo = 32'hFFFF_FFFF;
      end else if (div_ovf) begin
        fix_hi = 32'd0;
        fix_lo = 32'h8000_0000;
      end else begin
        fix_hi = rem_fix;
        fix_lo = quo_fix;
      end
    end
  end

  // HI/LO and completion pulse
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= (state == S_FIX);
      if (state == S_FIX) begin
        hi <= fix_hi;
        lo <= fix_lo;
      end else if ((state == S_IDLE) && i_start) begin
        if (i_op == MD_MTHI) hi <= i_src1;
        if (i_op == MD_MTLO) lo <= i_src1;
      end
    end
  end

  assign o_hi   = hi;
  assign o_lo   = lo;
  assign o_done = done;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed self-checking bench for muldiv_seq.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src1, src2;
  logic        hilo_rd;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  muldiv_seq dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .i_op      (op),
    .i_src1    (src1),
    .i_src2    (src2),
    .i_hilo_rd (hilo_rd),
    .o_busy    (busy),
    .o_stall   (stall),
    .o_done    (done),
    .o_hi      (hi),
    .o_lo      (lo)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered #1 after a rising edge; leaves #1 into cycle T+1.
  task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; src1 = a; src2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts cycles from T+1 until o_done; 33 means o_done in T+34.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int n;
    start_op(o, a, b);
    check({tag, "_busy"}, busy, 1'b1);
    wait_done(n);
    check({tag, "_latency"}, n, 33);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int ndone;
    rst = 1'b1; start = 1'b0; hilo_rd = 1'b0; op = 3'd0; src1 = '0; src2 = '0;
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    run_op("mult_neg", MD_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu", MD_MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA);

    // Reset in the middle of RUN.
    start_op(MD_MULT, 32'd7, 32'd3);
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1; #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    check("midrst_done", done, 1'b0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    ndone = 0;
    repeat (40) begin
      if (done === 1'b1) ndone++;
      @(posedge clk); #1;
    end
    check("midrst_no_done", ndone, 0);
    run_op("mult_after_rst", MD_MULT, 32'd7, 32'd3, 32'd0, 32'd21);

    run_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("divu_zero", MD_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

    // Stall: MFxx from T+5, a second op held from T+20, accepted at T+34.
    start_op(MD_MULTU, 32'd5, 32'd6);
    for (int c = 1; c <= 33; c++) begin
      if (c >= 20) begin
        hilo_rd = 1'b0; start = 1'b1; op = MD_MULTU; src1 = 32'd9; src2 = 32'd9;
      end else if (c >= 5) begin
        hilo_rd = 1'b1;
      end
      #1;
      check($sformatf("stall_c%0d", c), stall, (c >= 5));
      @(posedge clk); #1;
    end
    check("stall_t34", stall, 1'b0);
    check("stall_t34_done", done, 1'b1);
    check("stall_first_lo", lo, 32'd30);
    check("stall_first_hi", hi, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    check("second_busy", busy, 1'b1);
    wait_done(n);
    check("second_latency", n, 33);
    check("second_lo", lo, 32'd81);
    check("second_hi", hi, 32'd0);
    @(posedge clk); #1;

    // MTHI then MTLO on consecutive idle cycles.
    op = MD_MTHI; src1 = 32'hDEAD_BEEF; src2 = 32'd0; start = 1'b1; #1;
    check("mthi_stall", stall, 1'b0);
    @(posedge clk); #1;
    check("mthi_hi", hi, 32'hDEAD_BEEF);
    check("mthi_done", done, 1'b0);
    op = MD_MTLO; src1 = 32'h0000_1234; #1;
    check("mtlo_stall", stall, 1'b0);
    check("mtlo_busy", busy, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    check("mtlo_lo", lo, 32'h0000_1234);
    check("mtlo_hi_kept", hi, 32'hDEAD_BEEF);
    check("mtlo_done", done, 1'b0);

    // MFHI while idle does not stall.
    hilo_rd = 1'b1; #1;
    check("mfhi_idle_stall", stall, 1'b0);
    hilo_rd = 1'b0;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
